// File: rtl/mem_stage.sv
// Load/store stage between execute and register-file write port rd2; runs one op at a time on a req/ack bus.
// Latency: accept at edge N, bus request visible after N; ack at edge N+1 gives rd2 write-back for one cycle.
// Backpressure: in_ready is low for the whole bus transaction; mem_req is held until mem_ack or TIMEOUT expiry.
//
// Parameters: TIMEOUT - cycles mem_req may stay unacknowledged before the op is aborted (>= 2).
// Build option: define MEM_STAGE_MISALIGN_TRAP_EN to reject misaligned half/word accesses with bus_err;
//               when undefined, misaligned half/word addresses are force-aligned and proceed normally.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   op handshake from execute; in_store, in_funct3, in_addr, in_wdata, in_rd describe the op
//   mem_req/mem_ack     bus handshake; mem_we, mem_addr (word aligned), mem_be, mem_wdata, mem_rdata
//   rd2_addr/rd2_data   one-cycle load write-back (rd2_addr = 0 means no write)
//   bus_err             one-cycle pulse on timeout or illegal/rejected op
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  rd2_addr,
    output logic [31:0] rd2_data,
    output logic        bus_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, BUS} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          store_q;
    logic          uns_q;
    logic [1:0]    size_q;
    logic [1:0]    lane_q;
    logic [4:0]    rd_q;
    logic          mem_req_q;
    logic          mem_we_q;
    logic [31:0]   mem_addr_q;
    logic [3:0]    mem_be_q;
    logic [31:0]   mem_wdata_q;
    logic [4:0]    rd2_addr_q;
    logic [31:0]   rd2_data_q;
    logic          bus_err_q;

    // Decode of the op presented by execute
    logic [1:0]  size_d;
    logic        legal_d;
    logic        ok_d;
    logic [1:0]  lane_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] shifted_d;
    logic [31:0] load_d;

    assign size_d = in_funct3[1:0];

    // Stores only have 000/001/010; loads additionally have the unsigned 100/101 forms
    assign legal_d = in_store ? (!in_funct3[2] && size_d != 2'b11)
                              : (size_d != 2'b11 && !(in_funct3[2] && size_d == 2'b10));

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    logic misal_d;
    assign misal_d = (size_d == 2'b01 && in_addr[0]) || (size_d == 2'b10 && in_addr[1:0] != 2'b00);
    assign ok_d    = legal_d && !misal_d;
`else
    assign ok_d    = legal_d;
`endif

    // Lane is force-aligned to the access size; in the trap build only aligned ops get here anyway
    always_comb begin
        lane_d  = in_addr[1:0];
        be_d    = 4'b1111;
        wdata_d = in_wdata;
        case (size_d)
            2'b00: begin
                be_d    = 4'b0001 << in_addr[1:0];
                wdata_d = {4{in_wdata[7:0]}};
            end
            2'b01: begin
                lane_d  = {in_addr[1], 1'b0};
                be_d    = 4'b0011 << {in_addr[1], 1'b0};
                wdata_d = {2{in_wdata[15:0]}};
            end
            default: begin
                lane_d  = 2'b00;
                be_d    = 4'b1111;
                wdata_d = in_wdata;
            end
        endcase
    end

    // Load data alignment and extension from the latched lane/size
    assign shifted_d = mem_rdata >> {lane_q, 3'b000};

    always_comb begin
        load_d = shifted_d;
        case (size_q)
            2'b00:   load_d = {{24{!uns_q && shifted_d[7]}}, shifted_d[7:0]};
            2'b01:   load_d = {{16{!uns_q && shifted_d[15]}}, shifted_d[15:0]};
            default: load_d = shifted_d;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            store_q     <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= 2'b00;
            lane_q      <= 2'b00;
            rd_q        <= 5'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
            rd2_addr_q  <= 5'd0;
            rd2_data_q  <= 32'd0;
            bus_err_q   <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle
            bus_err_q  <= 1'b0;
            rd2_addr_q <= 5'd0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (ok_d) begin
                            state_q     <= BUS;
                            cnt_q       <= '0;
                            store_q     <= in_store;
                            uns_q       <= in_funct3[2];
                            size_q      <= size_d;
                            lane_q      <= lane_d;
                            rd_q        <= in_rd;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= in_store;
                            mem_addr_q  <= {in_addr[31:2], 2'b00};
                            mem_be_q    <= be_d;
                            mem_wdata_q <= in_store ? wdata_d : 32'd0;
                        end else begin
                            bus_err_q <= 1'b1;
                        end
                    end
                end
                BUS: begin
                    // An ack on the last allowed cycle still completes the op
                    if (mem_ack) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        mem_be_q  <= 4'd0;
                        if (!store_q) begin
                            rd2_addr_q <= rd_q;
                            rd2_data_q <= load_d;
                        end
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        mem_be_q  <= 4'd0;
                        bus_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign rd2_addr  = rd2_addr_q;
    assign rd2_data  = rd2_data_q;
    assign bus_err   = bus_err_q;

endmodule
